// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, per-frame classification,
// press/release debounce and a valid/ack key-event handshake with overrun flag.
module keypad_scan #(
    parameter int unsigned SCAN_DIV       = 2048,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    input  logic       key_ack,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       overrun
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [1:0]      col;
    logic [3:0]      row_s1;
    logic [3:0]      row_s2;
    logic [1:0]      acc_cnt;
    logic [3:0]      acc_code;
    logic [3:0]      cand;
    logic [CW-1:0]   deb_cnt;
    logic [CW-1:0]   rel_cnt;

    logic            tick;
    logic            frame_end;
    logic [3:0]      hits;
    logic [2:0]      col_cnt;
    logic [1:0]      col_row;
    logic [2:0]      tot;
    logic            fr_none;
    logic            fr_single;
    logic [3:0]      fr_code;
    logic            press_ev;

    // Frame classification including the column being sampled on this tick
    always_comb begin
        tick      = (presc == PW'(SCAN_DIV - 1));
        frame_end = tick && (col == 2'd3);
        hits      = ~row_s2;
        col_cnt   = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
        col_row   = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (hits[r]) col_row = 2'(r);
        end
        tot       = 3'(acc_cnt) + col_cnt;
        fr_none   = (tot == 3'd0);
        fr_single = (tot == 3'd1);
        fr_code   = (col_cnt != 3'd0) ? {col_row, col} : acc_code;
        press_ev  = 1'b0;
        if (frame_end && fr_single) begin
            if (state == ST_IDLE && DEBOUNCE_SCANS == 1)
                press_ev = 1'b1;
            else if (state == ST_DEBOUNCE && fr_code == cand &&
                     (deb_cnt + CW'(1)) == CW'(DEBOUNCE_SCANS))
                press_ev = 1'b1;
        end
    end

    // Prescaler, column drive, row synchroniser and frame accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            col      <= 2'd0;
            col_out  <= 4'b1110;
            row_s1   <= 4'b1111;
            row_s2   <= 4'b1111;
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
            if (tick) begin
                presc   <= '0;
                col     <= col + 2'd1;
                col_out <= ~(4'b0001 << (col + 2'd1));
                if (frame_end) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'd0;
                end else begin
                    acc_cnt <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
                    if (col_cnt != 3'd0) acc_code <= fr_code;
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Debounce FSM, evaluated once per frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cand     <= 4'd0;
            deb_cnt  <= '0;
            rel_cnt  <= '0;
            key_held <= 1'b0;
        end else if (frame_end) begin
            case (state)
                ST_IDLE: begin
                    if (fr_single) begin
                        cand    <= fr_code;
                        deb_cnt <= CW'(1);
                        rel_cnt <= '0;
                        if (DEBOUNCE_SCANS == 1) begin
                            state    <= ST_PRESSED;
                            key_held <= 1'b1;
                        end else begin
                            state <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (fr_single && fr_code == cand) begin
                        deb_cnt <= deb_cnt + CW'(1);
                        if (press_ev) begin
                            state    <= ST_PRESSED;
                            key_held <= 1'b1;
                            rel_cnt  <= '0;
                        end
                    end else if (fr_single) begin
                        cand    <= fr_code;
                        deb_cnt <= CW'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (fr_none) begin
                        if ((rel_cnt + CW'(1)) == CW'(DEBOUNCE_SCANS)) begin
                            state    <= ST_IDLE;
                            key_held <= 1'b0;
                            rel_cnt  <= '0;
                        end else begin
                            rel_cnt <= rel_cnt + CW'(1);
                        end
                    end else begin
                        rel_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

    // Event handshake; a press with a simultaneous ack keeps the event pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (press_ev) begin
            key_code  <= fr_code;
            key_valid <= 1'b1;
            if (key_valid && !key_ack) overrun <= 1'b1;
        end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2 and a keypad matrix model.
module tb_keypad_scan;

    logic        clk;
    logic        rst;
    logic [3:0]  row_in;
    logic        key_ack;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        overrun;
    logic [15:0] keys;

    int checks;
    int errors;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .key_ack   (key_ack),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row r pulled low when a pressed key (r,c) sits on a driven-low column c
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic        ack;
        logic        valid;
        logic [3:0]  code;
        logic        held;
        logic        ovr;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic v, input logic [3:0] c,
                            input logic h, input logic o);
        chk({tag, " key_valid"}, 16'(key_valid), 16'(v));
        chk({tag, " key_code"},  16'(key_code),  16'(c));
        chk({tag, " key_held"},  16'(key_held),  16'(h));
        chk({tag, " overrun"},   16'(overrun),   16'(o));
    endtask

    // Called #1 after an edge that ends a frame; returns #1 after a later frame-end edge
    task automatic run_frames(input int n, input logic ack);
        key_ack = ack;
        @(posedge clk);
        #1 key_ack = 1'b0;
        repeat (16*n - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        keys    = 16'h0000;
        key_ack = 1'b0;
        rst     = 1'b1;

        vt[0]  = '{16'h0200, 1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vt[1]  = '{16'h0200, 1, 1'b0, 1'b1, 4'd9,  1'b1, 1'b0};
        vt[2]  = '{16'h0200, 2, 1'b0, 1'b1, 4'd9,  1'b1, 1'b0};
        vt[3]  = '{16'h0200, 1, 1'b1, 1'b0, 4'd9,  1'b1, 1'b0};
        vt[4]  = '{16'h0000, 1, 1'b0, 1'b0, 4'd9,  1'b1, 1'b0};
        vt[5]  = '{16'h0000, 1, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0};
        vt[6]  = '{16'h0080, 1, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0};
        vt[7]  = '{16'h0000, 1, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0};
        vt[8]  = '{16'h8001, 5, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0};
        vt[9]  = '{16'h0001, 1, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0};
        vt[10] = '{16'h0001, 1, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0};
        vt[11] = '{16'h0000, 1, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0};
        vt[12] = '{16'h0000, 1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vt[13] = '{16'h0020, 2, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0};
        vt[14] = '{16'h0000, 2, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0};
        vt[15] = '{16'h8000, 2, 1'b0, 1'b1, 4'd15, 1'b1, 1'b1};
        vt[16] = '{16'h8000, 1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0};
        vt[17] = '{16'h0000, 2, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0};

        // Reset state and column stepping
        repeat (3) @(posedge clk);
        #1;
        chk("reset col_out", 16'(col_out), 16'hE);
        chk_outs("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            logic [3:0] exp_col;
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            chk($sformatf("col_out edge %0d", n), 16'(col_out), 16'(exp_col));
        end

        // Table: one record per stretch of whole frames
        for (int i = 0; i < 18; i++) begin
            keys = vt[i].keys;
            run_frames(vt[i].frames, vt[i].ack);
            chk_outs($sformatf("v%0d", i), vt[i].valid, vt[i].code, vt[i].held, vt[i].ovr);
        end

        // Press event landing on the same edge as an ack of the previous event
        keys = 16'h0008;
        run_frames(2, 1'b0);
        chk_outs("key3 press", 1'b1, 4'd3, 1'b1, 1'b0);
        keys = 16'h0000;
        run_frames(2, 1'b0);
        chk_outs("key3 release", 1'b1, 4'd3, 1'b0, 1'b0);
        keys = 16'h1000;
        repeat (16*2 - 1) @(posedge clk);
        #1 key_ack = 1'b1;
        @(posedge clk);
        #1 key_ack = 1'b0;
        chk_outs("event+ack", 1'b1, 4'd12, 1'b1, 1'b0);

        // Reset in the middle of DEBOUNCE with an event pending
        keys = 16'h0000;
        run_frames(2, 1'b0);
        keys = 16'h0040;
        run_frames(1, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst debounce col_out", 16'(col_out), 16'hE);
        chk_outs("rst debounce", 1'b0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_frames(1, 1'b0);
        chk_outs("after rst 1 frame", 1'b0, 4'd0, 1'b0, 1'b0);
        run_frames(1, 1'b0);
        chk_outs("redebounce", 1'b1, 4'd6, 1'b1, 1'b0);

        // Reset in the middle of PRESSED
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst pressed col_out", 16'(col_out), 16'hE);
        chk_outs("rst pressed", 1'b0, 4'd0, 1'b0, 1'b0);
        keys = 16'h0000;
        @(posedge clk);
        #1 rst = 1'b0;
        run_frames(2, 1'b0);
        chk_outs("no stale event", 1'b0, 4'd0, 1'b0, 1'b0);
        chk("final col_out", 16'(col_out), 16'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
